// File: rtl/cardinal_nic.sv
// cardinal_nic: PE-to-router NIC with one-entry in/out channel buffers and polarity-gated injection.
// Optional NIC_IRQ_EN adds an irq output that mirrors the input-buffer-full flag.
module cardinal_nic #(
  parameter int PACKET_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             addr,
  input  logic [PACKET_SIZE-1:0] d_in,
  output logic [PACKET_SIZE-1:0] d_out,
  input  logic                   nicEn,
  input  logic                   nicWrEn,
  output logic                   net_so,
  input  logic                   net_ro,
  output logic [PACKET_SIZE-1:0] net_do,
  input  logic                   net_si,
  output logic                   net_ri,
  input  logic [PACKET_SIZE-1:0] net_di,
  input  logic                   net_polarity
`ifdef NIC_IRQ_EN
  ,
  output logic                   irq
`endif
);
  logic [PACKET_SIZE-1:0] in_buf_q, in_buf_d, out_buf_q, out_buf_d, d_out_q, d_out_d;
  logic in_full_q, in_full_d, out_full_q, out_full_d;
  logic rd, wr, capture;
  logic [PACKET_SIZE-1:0] rd_data;
  assign net_ri  = ~in_full_q;
  assign net_do  = out_buf_q;
  assign net_so  = out_full_q & net_ro & (net_polarity == out_buf_q[PACKET_SIZE-1]);
  assign d_out   = d_out_q;
  assign rd      = nicEn & ~nicWrEn;
  assign wr      = nicEn & nicWrEn & (addr == 2'b10) & ~out_full_q;
  assign capture = net_si & ~in_full_q;
`ifdef NIC_IRQ_EN
  assign irq = in_full_q;
`endif
  always_comb begin
    rd_data    = addr == 2'b00 ? in_buf_q :
                 addr == 2'b01 ? {{(PACKET_SIZE-1){1'b0}}, in_full_q} :
                 addr == 2'b10 ? out_buf_q : {{(PACKET_SIZE-1){1'b0}}, out_full_q};
    d_out_d    = rd ? rd_data : d_out_q;
    in_buf_d   = capture ? net_di : in_buf_q;
    // capture beats a same-edge addr-00 read clearing the flag
    in_full_d  = capture ? 1'b1 : (rd && addr == 2'b00) ? 1'b0 : in_full_q;
    out_buf_d  = wr ? d_in : out_buf_q;
    out_full_d = wr ? 1'b1 : net_so ? 1'b0 : out_full_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q    <= '0;
      in_buf_q   <= '0;
      out_buf_q  <= '0;
      in_full_q  <= 1'b0;
      out_full_q <= 1'b0;
    end else begin
      d_out_q    <= d_out_d;
      in_buf_q   <= in_buf_d;
      out_buf_q  <= out_buf_d;
      in_full_q  <= in_full_d;
      out_full_q <= out_full_d;
    end
  end
endmodule

// File: tb/tb_cardinal_nic.sv
// tb_cardinal_nic: directed self-checking bench for cardinal_nic.
module tb_cardinal_nic;
  logic        clk = 0, reset = 1;
  logic [1:0]  addr = 0;
  logic [63:0] d_in = 0, d_out, net_do, net_di = 0;
  logic        nicEn = 0, nicWrEn = 0, net_so, net_ro = 0, net_si = 0, net_ri, pol;
  int checks = 0, failures = 0;
`ifdef NIC_IRQ_EN
  logic irq;
`endif
  cardinal_nic dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
    .net_polarity(pol)
`ifdef NIC_IRQ_EN
    , .irq(irq)
`endif
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) pol <= reset ? 1'b0 : ~pol;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [1:0] a);
    nicEn = 1; nicWrEn = 0; addr = a;
    cyc();
    nicEn = 0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [63:0] v);
    nicEn = 1; nicWrEn = 1; addr = a; d_in = v;
    cyc();
    nicEn = 0; nicWrEn = 0;
  endtask
  task automatic wait_send(input string tag, input logic [63:0] v);
    logic sent = 0;
    for (int i = 0; i < 4 && !sent; i++) begin
      check({tag, "_so_gate"}, {63'b0, net_so}, {63'b0, pol == v[63]});
      if (net_so) begin
        check({tag, "_do"}, net_do, v);
        sent = 1;
      end
      cyc();
    end
    check({tag, "_sent"}, {63'b0, sent}, 64'd1);
  endtask
  initial begin
    cyc(); cyc();
    reset = 0;
    cyc();
    check("rst_dout", d_out, 0);
    check("rst_ri", {63'b0, net_ri}, 1);
    check("rst_so", {63'b0, net_so}, 0);
    check("rst_do", net_do, 0);
`ifdef NIC_IRQ_EN
    check("rst_irq", {63'b0, irq}, 0);
`endif
    rd(2'b01); check("idle_in_stat", d_out, 0);
    rd(2'b11); check("idle_out_stat", d_out, 0);
    wr(2'b11, 64'hFF); wr(2'b00, 64'hFF);
    rd(2'b11); check("ign_wr_out_stat", d_out, 0);
    rd(2'b01); check("ign_wr_in_stat", d_out, 0);
    // VC=1 packet: may only leave on polarity 1
    net_ro = 1;
    wr(2'b10, 64'h8000_0000_0000_00AA);
    wait_send("vc1", 64'h8000_0000_0000_00AA);
    check("vc1_so_after", {63'b0, net_so}, 0);
    rd(2'b11); check("vc1_out_stat", d_out, 0);
    net_ro = 0;
    wr(2'b10, 64'h0000_0000_0000_1111);
    wr(2'b10, 64'h0000_0000_0000_2222);
    check("drop_do", net_do, 64'h1111);
    check("drop_so_ro0", {63'b0, net_so}, 0);
    rd(2'b11); check("drop_out_stat", d_out, 1);
    rd(2'b10); check("drop_out_buf", d_out, 64'h1111);
    net_ro = 1;
    wait_send("vc0", 64'h0000_0000_0000_1111);
    rd(2'b11); check("vc0_out_stat", d_out, 0);
    net_ro = 0;
    net_si = 1; net_di = 64'h0000_0000_1234_5678;
    cyc();
    net_si = 0;
    check("cap_ri", {63'b0, net_ri}, 0);
`ifdef NIC_IRQ_EN
    check("cap_irq", {63'b0, irq}, 1);
`endif
    rd(2'b01); check("cap_in_stat", d_out, 1);
    net_si = 1; net_di = 64'hDEAD;
    cyc();
    net_si = 0;
    rd(2'b00); check("cap_in_buf", d_out, 64'h1234_5678);
    check("cap_ri_back", {63'b0, net_ri}, 1);
`ifdef NIC_IRQ_EN
    check("cap_irq_fall", {63'b0, irq}, 0);
`endif
    rd(2'b01); check("cap_in_stat_clr", d_out, 0);
    rd(2'b00); check("stale_read", d_out, 64'h1234_5678);
    rd(2'b01); check("stale_no_change", d_out, 0);
    // capture coincident with an empty-buffer read returns stale data
    net_si = 1; net_di = 64'hCAFE_0000_BEEF_0001;
    nicEn = 1; nicWrEn = 0; addr = 2'b00;
    cyc();
    nicEn = 0; net_si = 0;
    check("race_stale", d_out, 64'h1234_5678);
    check("race_ri", {63'b0, net_ri}, 0);
    rd(2'b01); check("race_in_stat", d_out, 1);
    rd(2'b00); check("race_in_buf", d_out, 64'hCAFE_0000_BEEF_0001);
    net_si = 1; net_di = 64'h5555;
    cyc();
    net_si = 0;
    wr(2'b10, 64'h8000_0000_0000_0077);
    rd(2'b10);
    check("full_both_do", net_do, 64'h8000_0000_0000_0077);
    check("full_both_ri", {63'b0, net_ri}, 0);
    reset = 1;
    cyc();
    reset = 0; net_ro = 1;
    check("mid_rst_dout", d_out, 0);
    check("mid_rst_ri", {63'b0, net_ri}, 1);
    check("mid_rst_so", {63'b0, net_so}, 0);
    check("mid_rst_do", net_do, 0);
`ifdef NIC_IRQ_EN
    check("mid_rst_irq", {63'b0, irq}, 0);
`endif
    cyc();
    check("mid_rst_so2", {63'b0, net_so}, 0);
    rd(2'b01); check("mid_rst_in_stat", d_out, 0);
    rd(2'b11); check("mid_rst_out_stat", d_out, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cardinal_nic.md
# cardinal_nic

Network interface controller between one processing element (PE) and its cardinal router's PE port on the bidirectional ring. The processor side is a 2-bit-addressed register interface with a one-entry input channel buffer, a one-entry output channel buffer and two status registers. The network side injects packets into the router only in the cycle whose ring polarity matches the packet's virtual-channel bit, and accepts ejected packets into the input buffer. One instance sits beside each router; its network ports connect to that router's pesi/peri/pedi and peso/pero/pedo.

## Interface
- PACKET_SIZE, 64, packet and processor data width; bit PACKET_SIZE-1 is the VC (polarity) bit.
- clk  input  1  clock; reset is synchronous, active-high, on the rising edge.
- reset  input  1  synchronous active-high reset.
- addr  input  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  input  PACKET_SIZE  processor write data.
- d_out  output  PACKET_SIZE  processor read data, registered.
- nicEn  input  1  access enable.
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
- net_so  output  1  send strobe to router (drives router pesi).
- net_ro  input  1  router ready to accept (from router peri).
- net_do  output  PACKET_SIZE  packet to router (drives pedi).
- net_si  input  1  router send strobe (from router peso).
- net_ri  output  1  NIC ready to accept (drives router pero).
- net_di  input  PACKET_SIZE  packet from router (from pedo).
- net_polarity  input  1  ring polarity; 0 in the cycle after reset, toggles every cycle.
- irq  output  1  input-buffer-full interrupt; present only with NIC_IRQ_EN.

## Operation
- State: in_buf, in_full, out_buf, out_full, d_out register.
- Input channel: net_ri = ~in_full (combinational). On clk edge with net_si & net_ri: in_buf <= net_di, in_full <= 1. net_si while net_ri=0 is a protocol violation; ignored, buffer unchanged.
- Processor read (nicEn=1, nicWrEn=0): d_out <= selected value. addr 00: in_buf, and in_full <= 0 if set. addr 01: {zeros, in_full}. addr 10: out_buf. addr 11: {zeros, out_full}. d_out holds its value when no read occurs.
- Read of addr 00 with in_full=0: returns stale in_buf; no state change. If a network capture happens the same edge, capture wins (in_full <= 1).
- Processor write (nicEn=1, nicWrEn=1): addr 10 with out_full=0: out_buf <= d_in, out_full <= 1. addr 10 with out_full=1: dropped, no state change. Writes to 00, 01, 11: ignored.
- Output channel: net_do = out_buf always. net_so = out_full & net_ro & (net_polarity == out_buf[PACKET_SIZE-1]), combinational. On an edge with net_so=1, out_full <= 0.
- A write to addr 10 in the same cycle as a send is dropped (out_full still 1 in that cycle); the processor must poll addr 11.
- Payload bits are not modified; hop/dir fields are the router's concern.

## Timing
- Reset values: d_out=0, in_buf=0, out_buf=0, in_full=0, out_full=0, so net_ri=1, net_so=0, net_do=0, irq=0.
- Reset mid-operation discards both buffered packets with no send; net_so is 0 in the cycle reset is high only if out_full was already 0, otherwise the packet may be presented in that cycle but out_full clears at the edge regardless.
- Read latency: d_out valid 1 cycle after the read request.
- Write-to-send: a write at edge T gives out_full=1 after T; earliest net_so is the cycle after T, and otherwise the first later cycle with net_ro=1 and matching polarity (worst case 1 extra cycle while net_ro=1).
- Eject-to-status: capture at edge T; addr 01 read issued after T returns 1.
- Back-to-back ejects: in_full clears at the read edge; net_ri rises the following cycle.

## Configuration
- NIC_IRQ_EN: when defined, irq port exists and irq = in_full, registered through the same edge as in_full (deasserts the cycle after the addr 00 read edge). When undefined, the port and logic are absent; processor must poll addr 01.

## Test plan
- Reset then idle: d_out=0, net_ri=1, net_so=0, read addr 01 and 11 -> both return 0.
- Write 0x8000_0000_0000_00AA to addr 10 with net_ro=1: net_so asserts only in a cycle with net_polarity=1, net_do=that value, addr 11 reads 0 afterward.
- Second write to addr 10 while out_full=1 and net_ro=0 -> dropped; released packet is the first value.
- net_si with net_di=0x0000_0000_1234_5678: net_ri drops to 0, addr 01 reads 1, addr 00 read returns 0x12345678 next cycle, net_ri returns to 1 the following cycle.
- Network capture in the same cycle as an addr 00 read with in_full=0 -> stale data returned, in_full=1 afterwards.
- With NIC_IRQ_EN: irq rises after capture, falls after addr 00 read; reset asserted while both buffers full -> all outputs return to reset values.
